mesh_term_tx: RTL and testbench

- Terminal-side transmitter for one external port of the mesh_gnrtr router array.
- Accepts packet requests from a local host, builds mesh packets, and buffers them in a FIFO.
- Presents the FIFO head to the router through the router's input-side handshake (pndng_i_in / data_out_i_in / popin).
- Sits between host logic and one terminal of the mesh, replacing the bench driver in system-level builds.

---
 rtl/mesh_term_tx.sv | 113 +++++++++++
 tb/tb_mesh_term_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_term_tx.sv
// Terminal-side transmitter for one mesh port: validates host requests, builds
// mesh packets and buffers them in a FIFO presented to the router input handshake.
module mesh_term_tx #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLUMNS    = 4,
    parameter int unsigned PAKG_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  BDCST      = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_push,
    input  logic [3:0]           host_row,
    input  logic [3:0]           host_col,
    input  logic                 host_mode,
    input  logic [PAKG_SIZE-18:0] host_payload,
    output logic                 host_full,
    output logic [PAKG_SIZE-1:0] data_out_i_in,
    output logic                 pndng_i_in,
    input  logic                 popin,
    output logic [15:0]          sent_cnt,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          badaddr_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [3:0] ROW_MAX  = 4'(ROWS);
    localparam logic [3:0] ROW_EDGE = 4'(ROWS + 1);
    localparam logic [3:0] COL_MAX  = 4'(COLUMNS);
    localparam logic [3:0] COL_EDGE = 4'(COLUMNS + 1);

    logic [PAKG_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic                 addr_valid;
    logic                 full;
    logic                 pop_accept;
    logic                 push_accept;
    logic                 bad_hit;
    logic                 drop_hit;
    logic [PAKG_SIZE-1:0] pkt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Terminal addresses sit on the ring just outside the ROWS x COLUMNS core.
    always_comb begin
        addr_valid = 1'b0;
        if ((host_row >= 4'd1) && (host_row <= ROW_MAX) &&
            ((host_col == 4'd0) || (host_col == COL_EDGE)))
            addr_valid = 1'b1;
        if ((host_col >= 4'd1) && (host_col <= COL_MAX) &&
            ((host_row == 4'd0) || (host_row == ROW_EDGE)))
            addr_valid = 1'b1;
        if ({host_row, host_col} == BDCST)
            addr_valid = 1'b1;
    end

    assign full        = (count == CW'(FIFO_DEPTH));
    assign pndng_i_in  = (count != '0);
    assign host_full   = full;
    assign pop_accept  = popin & pndng_i_in;
    assign push_accept = host_push & addr_valid & (~full | pop_accept);
    assign bad_hit     = host_push & ~addr_valid;
    assign drop_hit    = host_push & addr_valid & full & ~pop_accept;
    assign pkt         = {8'h00, host_row, host_col, host_mode, host_payload};

    // Gate the head so stale storage is never shown while empty.
    assign data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_accept)
            mem[wr_ptr] <= pkt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_accept)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_accept && !pop_accept)
                count <= count + CW'(1);
            else if (pop_accept && !push_accept)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_cnt    <= '0;
            drop_cnt    <= '0;
            badaddr_cnt <= '0;
        end else begin
            if (pop_accept)
                sent_cnt <= sat_inc(sent_cnt);
            if (drop_hit)
                drop_cnt <= sat_inc(drop_cnt);
            if (bad_hit)
                badaddr_cnt <= sat_inc(badaddr_cnt);
        end
    end

endmodule

// File: tb/tb_mesh_term_tx.sv
// Self-checking bench for mesh_term_tx: address table, scoreboard of delivered
// packets, full/drop, simultaneous push/pop and asynchronous reset sequences.
module tb_mesh_term_tx;

    localparam int unsigned P     = 32;
    localparam int unsigned PL    = P - 17;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_push;
    logic [3:0]    host_row;
    logic [3:0]    host_col;
    logic          host_mode;
    logic [PL-1:0] host_payload;
    logic          host_full;
    logic [P-1:0]  data_out_i_in;
    logic          pndng_i_in;
    logic          popin;
    logic [15:0]   sent_cnt;
    logic [15:0]   drop_cnt;
    logic [15:0]   badaddr_cnt;

    mesh_term_tx dut (
        .clk          (clk),
        .reset        (reset),
        .host_push    (host_push),
        .host_row     (host_row),
        .host_col     (host_col),
        .host_mode    (host_mode),
        .host_payload (host_payload),
        .host_full    (host_full),
        .data_out_i_in(data_out_i_in),
        .pndng_i_in   (pndng_i_in),
        .popin        (popin),
        .sent_cnt     (sent_cnt),
        .drop_cnt     (drop_cnt),
        .badaddr_cnt  (badaddr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [P-1:0] sb_q[$];
    logic [15:0]  exp_sent, exp_drop, exp_bad;

    typedef struct {
        logic          push;
        logic [3:0]    row;
        logic [3:0]    col;
        logic          mode;
        logic [PL-1:0] pl;
        logic          pop;
        logic          exp_valid;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                            input logic m, input logic [PL-1:0] pl);
        return {8'h00, r, c, m, pl};
    endfunction

    // One clock of stimulus; vld is the expected address validity for this request.
    task automatic cycle(input logic push, input logic [3:0] r, input logic [3:0] c,
                         input logic m, input logic [PL-1:0] pl, input logic pop,
                         input logic vld);
        logic         pop_acc;
        logic         acc;
        int           sz;
        logic [P-1:0] head;
        host_push    = push;
        host_row     = r;
        host_col     = c;
        host_mode    = m;
        host_payload = pl;
        popin        = pop;
        #1;
        sz = sb_q.size();
        chk("pndng", 64'(pndng_i_in), 64'(sz != 0));
        chk("full", 64'(host_full), 64'(sz == DEPTH));
        if (sz != 0)
            chk("head", 64'(data_out_i_in), 64'(sb_q[0]));
        pop_acc = pop && (sz != 0);
        acc     = push && vld && ((sz < DEPTH) || pop_acc);
        if (pop_acc) begin
            head = sb_q.pop_front();
            if (exp_sent != 16'hFFFF) exp_sent++;
        end
        if (acc)
            sb_q.push_back(mk_pkt(r, c, m, pl));
        if (push && !vld && exp_bad != 16'hFFFF)
            exp_bad++;
        if (push && vld && sz == DEPTH && !pop_acc && exp_drop != 16'hFFFF)
            exp_drop++;
        @(posedge clk);
        #1;
        host_push = 1'b0;
        popin     = 1'b0;
        chk("sent_cnt", 64'(sent_cnt), 64'(exp_sent));
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("badaddr_cnt", 64'(badaddr_cnt), 64'(exp_bad));
    endtask

    task automatic idle_pop(input logic pop);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, '0, pop, 1'b1);
    endtask

    task automatic push_valid(input logic [PL-1:0] pl, input logic pop);
        cycle(1'b1, 4'd0, 4'd2, pl[0], pl, pop, 1'b1);
    endtask

    initial begin
        // {push,row,col,mode,payload,pop,expected address validity}
        vecs[0]  = '{1'b1, 4'd0,  4'd1,  1'b0, 15'h0101, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 4'd0,  4'd4,  1'b1, 15'h0202, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 4'd0,  4'd5,  1'b0, 15'h0303, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd0,  4'd0,  1'b0, 15'h0404, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'd1,  4'd0,  1'b1, 15'h0505, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 4'd4,  4'd5,  1'b0, 15'h0606, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 4'd5,  4'd5,  1'b1, 15'h0707, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'd5,  4'd1,  1'b0, 15'h0808, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 4'd2,  4'd2,  1'b0, 15'h0909, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'd7,  4'd0,  1'b1, 15'h0A0A, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'd15, 4'd15, 1'b1, 15'h0B0B, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 4'd1,  4'd5,  1'b0, 15'h0C0C, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 4'd5,  4'd0,  1'b0, 15'h0D0D, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'd5,  4'd4,  1'b1, 15'h0E0E, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'd2,  4'd2,  1'b0, 15'h0F0F, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 4'd0,  4'd15, 1'b0, 15'h1010, 1'b1, 1'b0};

        reset = 1'b0; host_push = 1'b0; host_row = '0; host_col = '0;
        host_mode = 1'b0; host_payload = '0; popin = 1'b0;
        exp_sent = '0; exp_drop = '0; exp_bad = '0;
        #2;
        chk("rst_pndng", 64'(pndng_i_in), 64'd0);
        chk("rst_full", 64'(host_full), 64'd0);
        chk("rst_data", 64'(data_out_i_in), 64'd0);
        chk("rst_sent", 64'(sent_cnt), 64'd0);
        #10;
        reset = 1'b1;

        // Single packet, exact bit layout, one-cycle pop.
        cycle(1'b1, 4'd0, 4'd1, 1'b1, 15'h05A5, 1'b0, 1'b1);
        chk("t1_pndng", 64'(pndng_i_in), 64'd1);
        chk("t1_data", 64'(data_out_i_in), 64'h0001_85A5);
        idle_pop(1'b1);
        chk("t1_empty", 64'(pndng_i_in), 64'd0);
        chk("t1_sent", 64'(sent_cnt), 64'd1);

        // Fill, overflow push, drain in order.
        for (int i = 0; i < 16; i++) push_valid(PL'(16'h100 + i), 1'b0);
        chk("t2_full", 64'(host_full), 64'd1);
        push_valid(15'h7777, 1'b0);
        chk("t2_drop", 64'(drop_cnt), 64'd1);
        chk("t2_still_full", 64'(host_full), 64'd1);
        for (int i = 0; i < 16; i++) idle_pop(1'b1);
        chk("t2_sent", 64'(sent_cnt), 64'd17);

        // Push while full with simultaneous pop.
        for (int i = 0; i < 16; i++) push_valid(PL'(16'h200 + i), 1'b0);
        push_valid(15'h3ABC, 1'b1);
        chk("t3_full", 64'(host_full), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 15; i++) idle_pop(1'b1);
        chk("t3_last", 64'(data_out_i_in), 64'(mk_pkt(4'd0, 4'd2, 1'b0, 15'h3ABC)));
        idle_pop(1'b1);
        chk("t3_empty", 64'(pndng_i_in), 64'd0);

        // Address validity table.
        for (int i = 0; i < 16; i++)
            cycle(vecs[i].push, vecs[i].row, vecs[i].col, vecs[i].mode,
                  vecs[i].pl, vecs[i].pop, vecs[i].exp_valid);
        while (sb_q.size() != 0) idle_pop(1'b1);

        // Interior and out-of-range addresses on an empty FIFO, then broadcast.
        cycle(1'b1, 4'd2, 4'd2, 1'b0, 15'h0001, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 4'd0, 1'b0, 15'h0002, 1'b0, 1'b0);
        chk("t4_no_pndng", 64'(pndng_i_in), 64'd0);
        cycle(1'b1, 4'hF, 4'hF, 1'b1, 15'h0003, 1'b0, 1'b1);
        chk("t4_bdcst", 64'(pndng_i_in), 64'd1);
        idle_pop(1'b1);

        // Pop on empty is ignored; held popin drains exactly three packets.
        idle_pop(1'b1);
        idle_pop(1'b1);
        for (int i = 0; i < 3; i++) push_valid(PL'(16'h400 + i), 1'b0);
        for (int i = 0; i < 4; i++) idle_pop(1'b1);
        chk("t5_empty", 64'(pndng_i_in), 64'd0);

        // Asynchronous reset with queued packets.
        for (int i = 0; i < 5; i++) push_valid(PL'(16'h500 + i), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_pndng", 64'(pndng_i_in), 64'd0);
        chk("t6_full", 64'(host_full), 64'd0);
        chk("t6_sent", 64'(sent_cnt), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);
        chk("t6_bad", 64'(badaddr_cnt), 64'd0);
        sb_q.delete();
        exp_sent = '0; exp_drop = '0; exp_bad = '0;
        @(negedge clk);
        reset = 1'b1;
        push_valid(15'h6666, 1'b0);
        chk("t6_one", 64'(data_out_i_in), 64'(mk_pkt(4'd0, 4'd2, 1'b0, 15'h6666)));
        idle_pop(1'b1);
        idle_pop(1'b0);
        chk("t6_sent1", 64'(sent_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
